sha_block_loader: RTL and testbench
===================================

SHA_BLOCK_LOADER -- requirements
Module: sha_block_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the write-beat width; legal values are 32, 64, 128 and 256.
REQ-002 SHALL have localparam BEATS = 512/DATA_W, meaning the number of beats per 512-bit block.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port write_en, input, 1 bit: beat-valid strobe.
REQ-006 SHALL have port data_in, input, DATA_W bits: message beat, big-endian word order.
REQ-007 SHALL have port data_last, input, 1 bit: marks the final beat of the final block of a message.
REQ-008 SHALL have port in_ready, output, 1 bit: the loader can accept a beat.
REQ-009 SHALL have port core_block, output, 512 bits: the assembled block presented to the SHA core.
REQ-010 SHALL have ports core_init and core_next, outputs, 1 bit each: start pulses for the first block and for each later block.
REQ-011 SHALL have ports core_ready, input, 1 bit, and core_digest_valid, input, 1 bit: core idle and core digest done.
REQ-012 SHALL have port core_digest, input, 256 bits: the digest from the core.
REQ-013 SHALL have port hashvalue, output, 256 bits: the final message digest.
REQ-014 SHALL have port valid, output, 1 bit: hashvalue holds a completed digest.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-016 SHALL accept a beat only when write_en=1 and in_ready=1; write_en while in_ready=0 is ignored and the beat is dropped.
REQ-017 SHALL store beat k (k=0..BEATS-1) at core_block[511-k*DATA_W -: DATA_W], so the first beat lands in the MSBs.
REQ-018 SHALL implement FSM states FILL, START, BUSY; in_ready=1 only in FILL.
REQ-019 FILL: beat counter increments per accepted beat; the accept at count BEATS-1 wraps the counter to 0 and moves to START.
REQ-020 SHALL latch data_last on the BEATS-1 beat as last_blk.
REQ-021 START: waits while core_ready=0; when core_ready=1, pulses core_init for exactly 1 cycle if first_blk=1, otherwise core_next, then moves to BUSY.
REQ-022 BUSY: on core_digest_valid=1 with last_blk=1, captures core_digest into hashvalue, sets valid=1 and first_blk=1, and returns to FILL.
REQ-023 BUSY: on core_digest_valid=1 with last_blk=0, sets first_blk=0 and returns to FILL.
REQ-024 core_block SHALL remain stable from entry into START until exit from BUSY.
REQ-025 valid SHALL stay 1 until the first beat of the next message is accepted, and SHALL clear in the cycle after that accept.
REQ-026 data_last=1 on an accepted beat with count != BEATS-1 SHALL: set err, discard the partial block, reset the counter to 0, set first_blk=1, and stay in FILL.
REQ-027 err SHALL clear on the next accepted count-0 beat that does not itself cause an error.
REQ-028 core_digest_valid outside BUSY SHALL be ignored.
REQ-029 Minimum latency from the last-beat accept to the core_init/core_next pulse SHALL be 1 cycle; from core_digest_valid to valid=1, 1 cycle.

Reset
REQ-030 On clr=0 (asynchronous, any state including mid-block or BUSY), all of the following SHALL take these values: state=FILL; counter=0; first_blk=1; last_blk=0; core_block=0; core_init=0; core_next=0; hashvalue=0; valid=0; err=0. in_ready SHALL be 1 once clr=1.

Structure
REQ-031 Package sha_pkg SHALL hold BLOCK_W=512, DIGEST_W=256 and the FSM state typedef.
REQ-032 Beat assembly SHALL sit in one sub-module, sha_block_buf (counter plus indexed write), parametrised by DATA_W.

Verification
REQ-033 DATA_W=128, real core, "abc" padded block in 4 beats, data_last on beat 4 -> one core_init, no core_next, valid=1, hashvalue=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-034 DATA_W=32, same message in 16 beats -> identical hash; core_init pulses exactly once.
REQ-035 DATA_W=128, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" in 2 blocks -> core_init then core_next, with valid=0 after block 1; hashvalue=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-036 Hold core_ready=0 for 20 cycles after the block fills; drive write_en=1 during START/BUSY -> no start pulse until core_ready=1; extra beats dropped; hash unchanged.
REQ-037 data_last on beat 2 of 4 -> err=1, partial block discarded, no core pulse; a following correct "abc" block -> err clears and the correct hash is produced.
REQ-038 Assert clr=0 after beat 3, and separately during BUSY -> all outputs return to reset values immediately; a subsequent full message hashes correctly.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared widths and FSM state encoding for the SHA block loader.
package sha_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 256;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/sha_block_buf.sv
// Beat assembly buffer: counts accepted beats and drops each one into its
// big-endian slot of the 512-bit block (beat 0 lands in the MSBs).
module sha_block_buf
    import sha_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int BEATS  = BLOCK_W / DATA_W
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               wr,
    input  logic               discard,
    input  logic [DATA_W-1:0]  data_in,
    output logic               at_first,
    output logic               at_last,
    output logic [BLOCK_W-1:0] block
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign at_first = (cnt_reg == '0);
    assign at_last  = (cnt_reg == LAST_IDX);

    // Beat counter: wraps after the final beat, restarts when a block is discarded.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_reg <= '0;
        end else if (discard) begin
            cnt_reg <= '0;
        end else if (wr) begin
            cnt_reg <= at_last ? '0 : cnt_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            localparam logic [CNT_W-1:0] IDX = CNT_W'(gi);
            logic [DATA_W-1:0] beat_reg;

            // Slot gi captures the beat accepted while the counter points at it.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    beat_reg <= '0;
                end else if (discard) begin
                    beat_reg <= '0;
                end else if (wr && (cnt_reg == IDX)) begin
                    beat_reg <= data_in;
                end
            end

            assign block[BLOCK_W-1-gi*DATA_W -: DATA_W] = beat_reg;
        end
    endgenerate

endmodule

// File: rtl/sha_block_loader.sv
// Collects message beats into 512-bit blocks, sequences the SHA core with
// init/next pulses and captures the final digest of each message.
module sha_block_loader
    import sha_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                write_en,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                data_last,
    output logic                in_ready,
    output logic [BLOCK_W-1:0]  core_block,
    output logic                core_init,
    output logic                core_next,
    input  logic                core_ready,
    input  logic                core_digest_valid,
    input  logic [DIGEST_W-1:0] core_digest,
    output logic [DIGEST_W-1:0] hashvalue,
    output logic                valid,
    output logic                err
);

    localparam int BEATS = BLOCK_W / DATA_W;

    state_t state_reg, state_next;
    logic   init_next, next_next;
    logic   first_blk_reg, last_blk_reg;
    logic   accept, bad_last, at_first, at_last;

    assign in_ready = (state_reg == ST_FILL);
    assign accept   = write_en && in_ready;
    // A data_last anywhere but the final beat of a block is a framing error.
    assign bad_last = accept && data_last && !at_last;

    sha_block_buf #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_buf (
        .clk      (clk),
        .clr      (clr),
        .wr       (accept && !bad_last),
        .discard  (bad_last),
        .data_in  (data_in),
        .at_first (at_first),
        .at_last  (at_last),
        .block    (core_block)
    );

    // State register and registered one-cycle core start pulses.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= ST_FILL;
            core_init <= 1'b0;
            core_next <= 1'b0;
        end else begin
            state_reg <= state_next;
            core_init <= init_next;
            core_next <= next_next;
        end
    end

    // Next-state logic; the start pulse is chosen by whether this block opens a message.
    always_comb begin
        state_next = state_reg;
        init_next  = 1'b0;
        next_next  = 1'b0;
        case (state_reg)
            ST_FILL: begin
                if (accept && at_last) state_next = ST_START;
            end
            ST_START: begin
                if (core_ready) begin
                    state_next = ST_BUSY;
                    init_next  = first_blk_reg;
                    next_next  = !first_blk_reg;
                end
            end
            ST_BUSY: begin
                if (core_digest_valid) state_next = ST_FILL;
            end
            default: state_next = ST_FILL;
        endcase
    end

    // Message bookkeeping: block position flags, digest capture, valid and error flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            first_blk_reg <= 1'b1;
            last_blk_reg  <= 1'b0;
            hashvalue     <= '0;
            valid         <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (accept) begin
                if (bad_last) begin
                    err           <= 1'b1;
                    first_blk_reg <= 1'b1;
                end else begin
                    if (at_first) err <= 1'b0;
                    if (at_last) last_blk_reg <= data_last;
                end
                // The first beat of a new message retires the previous digest.
                if (at_first) valid <= 1'b0;
            end
            if ((state_reg == ST_BUSY) && core_digest_valid) begin
                if (last_blk_reg) begin
                    hashvalue     <= core_digest;
                    valid         <= 1'b1;
                    first_blk_reg <= 1'b1;
                end else begin
                    first_blk_reg <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha_block_loader.sv
// Bench for sha_block_loader: two instances (128-bit and 32-bit beats) share a
// behavioural SHA-256 core; messages are padded and hashed by a reference model.
module tb_sha_block_loader;

    localparam int TMO = 2000;
    localparam int LAT = 6;
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_2BLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b0;

    // 128-bit beat instance
    logic         we_a = 1'b0, last_a = 1'b0;
    logic [127:0] din_a = '0;
    logic         rdy_a, init_a, next_a, valid_a, err_a;
    logic [511:0] blk_a;
    logic [255:0] hash_a;

    // 32-bit beat instance
    logic         we_b = 1'b0, last_b = 1'b0;
    logic [31:0]  din_b = '0;
    logic         rdy_b, init_b, next_b, valid_b, err_b;
    logic [511:0] blk_b;
    logic [255:0] hash_b;

    // shared core model
    logic         ready_en = 1'b1;
    logic         core_dv = 1'b0;
    logic         core_ready;
    logic [255:0] core_digest;
    logic [255:0] h_state = '0;
    int           busy_cnt = 0;
    int           n_init_a = 0, n_next_a = 0, n_init_b = 0, n_next_b = 0;
    logic         valid_at_next = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    int s_init_a, s_next_a, s_init_b, s_next_b;

    logic [511:0] blk_q [$];
    byte unsigned msg [$];

    sha_block_loader #(.DATA_W(128)) dut_a (
        .clk(clk), .clr(clr), .write_en(we_a), .data_in(din_a), .data_last(last_a),
        .in_ready(rdy_a), .core_block(blk_a), .core_init(init_a), .core_next(next_a),
        .core_ready(core_ready), .core_digest_valid(core_dv), .core_digest(core_digest),
        .hashvalue(hash_a), .valid(valid_a), .err(err_a));

    sha_block_loader #(.DATA_W(32)) dut_b (
        .clk(clk), .clr(clr), .write_en(we_b), .data_in(din_b), .data_last(last_b),
        .in_ready(rdy_b), .core_block(blk_b), .core_init(init_b), .core_next(next_b),
        .core_ready(core_ready), .core_digest_valid(core_dv), .core_digest(core_digest),
        .hashvalue(hash_b), .valid(valid_b), .err(err_b));

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // One SHA-256 compression round over a 512-bit block.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Behavioural SHA core: starts on init/next from either loader, digest after LAT cycles.
    always @(posedge clk) begin
        core_dv <= 1'b0;
        if (init_a || next_a || init_b || next_b) begin
            h_state  <= sha_compress((init_a || init_b) ? IV : h_state, (init_a || next_a) ? blk_a : blk_b);
            busy_cnt <= LAT;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) core_dv <= 1'b1;
        end
        if (init_a) n_init_a <= n_init_a + 1;
        if (next_a) n_next_a <= n_next_a + 1;
        if (init_b) n_init_b <= n_init_b + 1;
        if (next_b) n_next_b <= n_next_b + 1;
        if (next_a) valid_at_next <= valid_a;
    end

    assign core_ready  = (busy_cnt == 0) && ready_en;
    assign core_digest = h_state;

    task automatic chk(input logic [511:0] obs, input logic [511:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Standard SHA-256 padding of msg into blk_q.
    task automatic pad_msg();
        byte unsigned p [$];
        longint unsigned bitlen;
        logic [511:0] blk;
        p = msg;
        bitlen = longint'(msg.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bitlen >> (8*i)));
        blk_q.delete();
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk = {blk[503:0], p[bi*64 + j]};
            blk_q.push_back(blk);
        end
    endtask

    task automatic set_msg(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
        pad_msg();
    endtask

    task automatic set_random_msg();
        int len;
        len = $urandom_range(0, 200);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        pad_msg();
    endtask

    function automatic logic [255:0] ref_hash();
        logic [255:0] h;
        h = IV;
        foreach (blk_q[i]) h = sha_compress(h, blk_q[i]);
        return h;
    endfunction

    function automatic logic [127:0] beat_of(input int dw, input int i);
        int bpb;
        logic [511:0] sh;
        bpb = 512 / dw;
        sh = blk_q[i / bpb] << ((i % bpb) * dw);
        return sh[511:384];
    endfunction

    task automatic snap();
        s_init_a = n_init_a; s_next_a = n_next_a;
        s_init_b = n_init_b; s_next_b = n_next_b;
    endtask

    task automatic send_beat(input int dw, input logic [127:0] d, input logic last);
        int guard;
        guard = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        while (((dw == 128) ? rdy_a : rdy_b) !== 1'b1 && guard < TMO) begin
            @(posedge clk); #1;
            guard++;
        end
        chk(512'(guard < TMO), 512'(1), "ready_wait");
        if (dw == 128) begin we_a = 1'b1; din_a = d; last_a = last; end
        else begin we_b = 1'b1; din_b = d[127:96]; last_b = last; end
        @(posedge clk); #1;
        we_a = 1'b0; last_a = 1'b0; we_b = 1'b0; last_b = 1'b0;
    endtask

    task automatic send_range(input int dw, input int from, input int to);
        int total;
        total = blk_q.size() * (512 / dw);
        for (int i = from; i <= to; i++) send_beat(dw, beat_of(dw, i), i == total - 1);
    endtask

    task automatic send_all(input int dw);
        send_range(dw, 0, blk_q.size() * (512 / dw) - 1);
    endtask

    task automatic wait_valid(input int dw, input string tag);
        int guard;
        guard = 0;
        while (((dw == 128) ? valid_a : valid_b) !== 1'b1 && guard < TMO) begin
            @(posedge clk); #1;
            guard++;
        end
        chk(512'(guard < TMO), 512'(1), tag);
    endtask

    task automatic chk_reset_a(input string tag);
        chk(512'(valid_a), 512'(0), {tag, "_valid"});
        chk(512'(err_a), 512'(0), {tag, "_err"});
        chk(512'(hash_a), 512'(0), {tag, "_hash"});
        chk(blk_a, 512'(0), {tag, "_block"});
        chk(512'({init_a, next_a}), 512'(0), {tag, "_pulses"});
        chk(512'(rdy_a), 512'(1), {tag, "_in_ready"});
    endtask

    initial begin
        logic [511:0] held;
        int guard;

        // Reset state of both instances
        #12;
        chk_reset_a("por");
        chk(512'({valid_b, err_b, init_b, next_b}), 512'(0), "por_b_flags");
        chk(blk_b, 512'(0), "por_b_block");
        @(posedge clk); #1;
        clr = 1'b1;
        $display("reset released");

        // "abc" in 4 beats on the 128-bit loader
        set_msg("abc"); snap();
        send_all(128);
        wait_valid(128, "abc128_wait");
        chk(512'(hash_a), 512'(H_ABC), "abc128_hash");
        chk(512'(n_init_a - s_init_a), 512'(1), "abc128_init");
        chk(512'(n_next_a - s_next_a), 512'(0), "abc128_next");
        $display("abc 128-bit: hash %h", hash_a);

        // "abc" in 16 beats on the 32-bit loader; the 128-bit one must ignore its digest
        snap();
        send_all(32);
        wait_valid(32, "abc32_wait");
        chk(512'(hash_b), 512'(H_ABC), "abc32_hash");
        chk(512'(n_init_b - s_init_b), 512'(1), "abc32_init");
        chk(512'(n_next_b - s_next_b), 512'(0), "abc32_next");
        chk(512'(hash_a), 512'(H_ABC), "idle_digest_ignored");
        chk(512'(valid_a), 512'(1), "valid_held");
        $display("abc 32-bit: hash %h", hash_b);

        // Two-block message
        set_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"); snap();
        send_all(128);
        wait_valid(128, "two_blk_wait");
        chk(512'(hash_a), 512'(H_2BLK), "two_blk_hash");
        chk(512'(n_init_a - s_init_a), 512'(1), "two_blk_init");
        chk(512'(n_next_a - s_next_a), 512'(1), "two_blk_next");
        chk(512'(valid_at_next), 512'(0), "two_blk_valid_mid");
        $display("two-block: hash %h", hash_a);

        // Core stalled for 20 cycles with write_en hammering during START and BUSY
        set_msg("abc"); snap();
        ready_en = 1'b0;
        send_all(128);
        for (int c = 0; c < 20; c++) begin
            we_a = 1'b1; din_a = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        chk(512'(rdy_a), 512'(0), "stall_in_ready");
        chk(512'(n_init_a - s_init_a), 512'(0), "stall_no_init");
        chk(blk_a, blk_q[0], "stall_block_stable");
        ready_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            din_a = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        we_a = 1'b0;
        wait_valid(128, "stall_wait");
        chk(512'(hash_a), 512'(H_ABC), "stall_hash");
        chk(512'(n_init_a - s_init_a), 512'(1), "stall_init");
        chk(blk_a, blk_q[0], "stall_block_after");
        $display("stalled core: hash %h", hash_a);

        // data_last on beat 2 of 4, then a clean "abc" block
        snap();
        send_beat(128, beat_of(128, 0), 1'b0);
        chk(512'(valid_a), 512'(0), "valid_clear_first_beat");
        send_beat(128, beat_of(128, 1), 1'b1);
        chk(512'(err_a), 512'(1), "early_last_err");
        repeat (3) begin @(posedge clk); #1; end
        chk(512'(rdy_a), 512'(1), "early_last_stay_fill");
        chk(512'(n_init_a - s_init_a + n_next_a - s_next_a), 512'(0), "early_last_no_pulse");
        send_range(128, 0, 0);
        chk(512'(err_a), 512'(0), "err_clears");
        send_range(128, 1, 3);
        wait_valid(128, "recover_wait");
        chk(512'(hash_a), 512'(H_ABC), "recover_hash");
        chk(512'(n_init_a - s_init_a), 512'(1), "recover_init");
        $display("early data_last recovery: hash %h", hash_a);

        // Reset after beat 3
        send_range(128, 0, 2);
        #2 clr = 1'b0;
        #1 chk_reset_a("rst_mid");
        @(posedge clk); #1;
        clr = 1'b1;
        snap();
        send_all(128);
        wait_valid(128, "rst_mid_wait");
        chk(512'(hash_a), 512'(H_ABC), "rst_mid_hash");
        $display("reset mid-block: hash %h", hash_a);

        // Reset while BUSY
        snap();
        send_all(128);
        guard = 0;
        while (n_init_a == s_init_a && guard < TMO) begin @(posedge clk); #1; guard++; end
        chk(512'(guard < TMO), 512'(1), "busy_init_wait");
        repeat (2) begin @(posedge clk); #1; end
        #2 clr = 1'b0;
        #1 chk_reset_a("rst_busy");
        @(posedge clk); #1;
        clr = 1'b1;
        set_random_msg(); snap();
        send_all(128);
        wait_valid(128, "rst_busy_wait");
        chk(512'(hash_a), 512'(ref_hash()), "rst_busy_hash");
        $display("reset in BUSY: %0d bytes hash %h", msg.size(), hash_a);

        // Random messages on randomly chosen beat widths
        for (int t = 0; t < 6; t++) begin
            int dw;
            dw = ($urandom_range(0, 1) == 0) ? 128 : 32;
            set_random_msg(); snap();
            send_all(dw);
            wait_valid(dw, "rand_wait");
            held = (dw == 128) ? 512'(hash_a) : 512'(hash_b);
            chk(held, 512'(ref_hash()), "rand_hash");
            if (dw == 128) begin
                chk(512'(n_init_a - s_init_a), 512'(1), "rand_init");
                chk(512'(n_next_a - s_next_a), 512'(blk_q.size() - 1), "rand_next");
            end else begin
                chk(512'(n_init_b - s_init_b), 512'(1), "rand_init");
                chk(512'(n_next_b - s_next_b), 512'(blk_q.size() - 1), "rand_next");
            end
            $display("random msg %0d: width %0d, %0d bytes, %0d blocks, hash %h",
                     t, dw, msg.size(), blk_q.size(), held[255:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
